// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART.
//
// The transmitter accepts one word per valid/ready handshake and sends
// start, data (LSB first), optional parity and stop bits at a runtime bit
// period. The receiver synchronises the line, checks parity and stop bits,
// and pushes {ferr, perr, data} into a show-ahead FIFO with a sticky
// overrun flag.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-low reset
//   clks_per_bit  clocks per bit (values below 4 act as 4), latched per frame
//   tx_data       word to transmit
//   tx_valid      tx_data valid
//   tx_ready      transmitter idle, can accept a word
//   tx_bit        serial TX line, idle high
//   tx_done       one-cycle pulse in the last cycle of the final stop bit
//   rx_bit        serial RX line, asynchronous to clk
//   rx_data       FIFO head word (0 while empty)
//   rx_perr       parity error flag of head word
//   rx_ferr       framing error flag of head word
//   rx_valid      FIFO not empty
//   rx_ready      pop head word when rx_valid is high
//   rx_count      FIFO occupancy
//   rx_overrun    sticky: a word was dropped because the FIFO was full
//   err_clr       clears rx_overrun
module uart_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int RX_DEPTH   = 4,
  parameter int DIV_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIV_W-1:0]                clks_per_bit,
  input  logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            tx_bit,
  output logic                            tx_done,
  input  logic                            rx_bit,
  output logic [DATA_WIDTH-1:0]           rx_data,
  output logic                            rx_perr,
  output logic                            rx_ferr,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(RX_DEPTH+1)-1:0]   rx_count,
  output logic                            rx_overrun,
  input  logic                            err_clr
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = $clog2(RX_DEPTH + 1);
  localparam int FW    = DATA_WIDTH + 2;

  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(4)) ? DIV_W'(4) : d;
  endfunction

  // Even mode: XOR of the data; odd mode: its complement.
  function automatic logic par_of(input logic [DATA_WIDTH-1:0] d);
    return (PARITY == 2) ? ~^d : ^d;
  endfunction

  // ---------------------------------------------------------------- TX
  logic [2:0]            tx_state;
  logic [DIV_W-1:0]      tx_div;
  logic [DIV_W-1:0]      tx_cnt;
  logic [IDX_W-1:0]      tx_idx;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_par;
  logic                  tx_last;

  assign tx_last  = (tx_cnt == tx_div - DIV_W'(1));
  assign tx_ready = (tx_state == S_IDLE);
  assign tx_done  = (tx_state == S_STOP) && tx_last && (tx_idx == STOP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_bit   <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_div   <= DIV_W'(4);
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_valid) begin
            tx_state <= S_START;
            tx_bit   <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_div   <= eff_div(clks_per_bit);
          end
        end
        S_START: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_state <= S_DATA;
            tx_bit   <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_idx == DATA_LAST) begin
              tx_idx <= '0;
              if (PARITY != 0) begin
                tx_state <= S_PARITY;
                tx_bit   <= tx_par;
              end else begin
                tx_state <= S_STOP;
                tx_bit   <= 1'b1;
              end
            end else begin
              tx_idx <= tx_idx + IDX_W'(1);
              // tx_shift[0] is the bit just sent; [1] is the next one.
              tx_bit <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
          end
        end
        S_PARITY: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= S_STOP;
            tx_bit   <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
          end
        end
        S_STOP: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_idx == STOP_LAST) begin
              tx_state <= S_IDLE;
            end else begin
              tx_idx <= tx_idx + IDX_W'(1);
            end
          end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
          end
        end
        default: begin
          tx_state <= S_IDLE;
          tx_bit   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_state == S_IDLE && tx_valid) begin
      tx_shift <= tx_data;
      tx_par   <= par_of(tx_data);
    end else if (tx_state == S_DATA && tx_last && tx_idx != DATA_LAST) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // ---------------------------------------------------------------- RX
  // Two-flop synchroniser; only rx_sync_p1 is used by the FSM.
  logic                  rx_meta_p0;
  logic                  rx_sync_p1;
  logic [2:0]            rx_state;
  logic [DIV_W-1:0]      rx_div;
  logic [DIV_W-1:0]      rx_cnt;
  logic [IDX_W-1:0]      rx_idx;
  logic                  rx_push_p2;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_perr_acc;
  logic                  rx_ferr_acc;
  logic                  rx_mid;
  logic                  rx_end;

  assign rx_mid = (rx_cnt == (rx_div >> 1) - DIV_W'(1));
  assign rx_end = (rx_cnt == rx_div - DIV_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_state   <= S_IDLE;
      rx_div     <= DIV_W'(4);
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_push_p2 <= 1'b0;
    end else begin
      rx_meta_p0 <= rx_bit;
      rx_sync_p1 <= rx_meta_p0;
      rx_push_p2 <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rx_sync_p1) begin
            rx_state <= S_START;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_div   <= eff_div(clks_per_bit);
          end
        end
        S_START: begin
          if (rx_mid) begin
            rx_cnt <= '0;
            // A line that is high again at the start-bit centre was a glitch.
            rx_state <= rx_sync_p1 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
        S_DATA: begin
          if (rx_end) begin
            rx_cnt <= '0;
            if (rx_idx == DATA_LAST) begin
              rx_idx   <= '0;
              rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              rx_idx <= rx_idx + IDX_W'(1);
            end
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
        S_PARITY: begin
          if (rx_end) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
        S_STOP: begin
          if (rx_end) begin
            rx_cnt <= '0;
            if (rx_idx == STOP_LAST) begin
              rx_state   <= S_IDLE;
              rx_push_p2 <= 1'b1;
            end else begin
              rx_idx <= rx_idx + IDX_W'(1);
            end
          end else begin
            rx_cnt <= rx_cnt + DIV_W'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Error accumulators clear at the start-bit centre rather than at start
  // detection, so a new frame detected right after a stop bit cannot
  // disturb the word being pushed.
  always_ff @(posedge clk) begin
    if (rx_state == S_START && rx_mid) begin
      rx_perr_acc <= 1'b0;
      rx_ferr_acc <= 1'b0;
    end
    if (rx_state == S_DATA && rx_end) begin
      rx_shift <= {rx_sync_p1, rx_shift[DATA_WIDTH-1:1]};
    end
    if (rx_state == S_PARITY && rx_end) begin
      rx_perr_acc <= (rx_sync_p1 != par_of(rx_shift));
    end
    if (rx_state == S_STOP && rx_end && !rx_sync_p1) begin
      rx_ferr_acc <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [FW-1:0]    fifo_mem [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [FW-1:0]    head;
  logic             pop;
  logic             full;
  logic             do_wr;

  assign rx_valid = (rx_count != '0);
  assign pop      = rx_valid && rx_ready;
  assign full     = (rx_count == CNT_W'(RX_DEPTH));
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign do_wr    = rx_push_p2 && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      fifo_mem[wr_ptr] <= {rx_ferr_acc, rx_perr_acc, rx_shift};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_count   <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, pop})
        2'b10:   rx_count <= rx_count + CNT_W'(1);
        2'b01:   rx_count <= rx_count - CNT_W'(1);
        default: rx_count <= rx_count;
      endcase
      if (rx_push_p2 && full && !pop) begin
        rx_overrun <= 1'b1;
      end else if (err_clr) begin
        rx_overrun <= 1'b0;
      end
    end
  end

  assign head    = fifo_mem[rd_ptr];
  assign rx_data = rx_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rx_perr = rx_valid && head[DATA_WIDTH];
  assign rx_ferr = rx_valid && head[DATA_WIDTH+1];

endmodule
